dht11_reader: RTL and testbench
===============================

Name: dht11_reader

Overview:
- Single-wire DHT11 humidity/temperature acquisition engine.
- Sits upstream of the LCD text controller and the buzzer's temperature-alarm compare; its temp_humi output is the TempHumi bus.
- Periodically issues the DHT11 start pulse, decodes the 40-bit response by pulse-width measurement, checks the checksum, and holds the last good reading.

Parameters:
- CLK_FREQ, 12000000, sys_clk frequency in Hz; used to derive a 1 us tick as CLK_FREQ/1000000 cycles.
- POLL_MS, 2000, interval between reads in ms; the first read also occurs POLL_MS after reset.
- START_MS, 20, duration the host drives the line low for the start pulse, in ms.
- BIT1_US, 40, data-bit high-time threshold in us; high time > BIT1_US decodes as 1.
- TIMEOUT_US, 200, maximum time spent in any single wait-for-edge state before the read is aborted, in us.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst, in, 1, asynchronous active-high reset.
- dht11, inout, 1, open-drain data line; the block drives only 0 or Z and relies on an external pull-up.
- temp_humi, out, 16, last valid reading: [15:8] = temperature integer in °C, [7:0] = relative humidity integer in %.
- data_valid, out, 1, one-cycle pulse when temp_humi is updated.
- read_err, out, 1, one-cycle pulse when a read aborts (timeout or checksum failure).

Behaviour:
- Reset values: temp_humi=16'h0000, data_valid=0, read_err=0, dht11 released (Z), FSM in IDLE, all counters 0.
- Input path:
  - dht11 passes through a 2-FF synchronizer; edges are detected on the synchronized value.
  - All decisions use the synchronized value, so each edge carries 2 cycles of latency.
- Timebase:
  - A free-running prescaler produces us_tick once every CLK_FREQ/1000000 cycles.
  - A us_cnt (16 bit, saturating) clears on every state entry and increments on us_tick.
  - A separate ms counter serves IDLE and START.
- FSM states and transitions:
  - IDLE: line released. After POLL_MS ms -> START.
  - START: drive dht11=0. After START_MS ms -> RELEASE.
  - RELEASE: line released. Synchronized falling edge -> RESP_LOW.
  - RESP_LOW: sensor holds the line low (~80 us). Rising edge -> RESP_HIGH.
  - RESP_HIGH: sensor holds the line high (~80 us). Falling edge -> BIT_LOW, with bit_cnt=0.
  - BIT_LOW: bit preamble low (~50 us). Rising edge -> BIT_HIGH.
  - BIT_HIGH: measure high time. On falling edge:
    - shift (us_cnt > BIT1_US) into a 40-bit shift register, MSB first, and increment bit_cnt;
    - if bit_cnt reaches 40 -> CHECK, else -> BIT_LOW.
  - CHECK (1 cycle):
    - Frame bytes are b0..b4 = humidity int, humidity dec, temperature int, temperature dec, checksum.
    - Pass condition: (b0+b1+b2+b3) mod 256 == b4. Use an 8-bit sum and discard the carry.
    - Pass: temp_humi <= {b2,b0}, data_valid=1 for one cycle.
    - Fail: temp_humi unchanged, read_err=1.
    - -> IDLE in both cases.
- Timeout:
  - In RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, reaching us_cnt == TIMEOUT_US pulses read_err, releases the line and -> IDLE.
  - Partial data is discarded and temp_humi is unchanged.
- The final falling edge after bit 40 (the sensor's trailing ~50 us low and release) is not waited for; IDLE ignores line activity.
- The block never drives the line outside START, and is released within 1 cycle of leaving START.
- data_valid and read_err are mutually exclusive and never asserted for more than one cycle.
- temp_humi changes only on the data_valid cycle.
- Reset mid-read: the line is released immediately, the FSM returns to IDLE, and the POLL_MS wait restarts.
- After a failure, the retry occurs on the next POLL_MS interval; there is no immediate retry.

Test Plan:
Run the bench with CLK_FREQ=2000000, POLL_MS=2, START_MS=1 and a behavioural sensor model with pull-up.
- Good frame: sensor returns 0x3C,0x00,0x19,0x00,0x55 -> dht11 low for 1 ms about 2 ms after reset; data_valid pulses once; temp_humi=16'h193C; read_err stays 0.
- Bad checksum: frame 0x3C,0x00,0x19,0x00,0x56 after a good read -> read_err pulses once; temp_humi holds 16'h193C; no data_valid.
- No sensor (line stays high after START) -> read_err exactly TIMEOUT_US us after entering RELEASE; next start pulse follows POLL_MS later.
- Bit-threshold boundary: high times of 26 us and 70 us, plus 40 us and 41 us -> decoded as 0,1,0,1 respectively.
- Checksum wrap: frame 0xFF,0x01,0x10,0x05,0x15 (sum 0x115) -> data_valid; temp_humi=16'h10FF.
- Reset mid-frame: assert sys_rst during bit 20 -> all outputs return to reset values, line released immediately, clean read completes on the next poll.

Source files
------------

// File: rtl/dht11_reader.sv
`timescale 1ns/1ps
// DHT11 single-wire reader: periodic start pulse, pulse-width bit decode,
// checksum-gated capture of temperature/humidity integer bytes.
module dht11_reader #(
  parameter int CLK_FREQ   = 12000000,
  parameter int POLL_MS    = 2000,
  parameter int START_MS   = 20,
  parameter int BIT1_US    = 40,
  parameter int TIMEOUT_US = 200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  inout  wire         dht11,
  output logic [15:0] temp_humi,
  output logic        data_valid,
  output logic        read_err
);
  localparam int DIV = (CLK_FREQ / 1000000 > 0) ? CLK_FREQ / 1000000 : 1;

  typedef enum logic [2:0] {
    IDLE, START, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t      state, state_n;
  logic [15:0] presc;
  logic        us_tick;
  logic [15:0] us_cnt;
  logic [9:0]  ms_sub;
  logic [15:0] ms_cnt;
  logic [39:0] shift;
  logic [5:0]  bit_cnt;
  logic        dht_p0, dht_p1, dht_p2;
  logic        rise, fall, timeout;
  logic        shift_en, set_valid, set_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bytes are humidity int, humidity dec, temperature int, temperature dec; carry dropped.
  function automatic logic [7:0] checksum(input logic [39:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

  assign us_tick = (presc == 16'(DIV - 1));
  assign rise    = dht_p1 & ~dht_p2;
  assign fall    = ~dht_p1 & dht_p2;
  assign timeout = (us_cnt == 16'(TIMEOUT_US));
  assign dht11   = (state == START) ? 1'b0 : 1'bz;

  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    set_valid = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE:      if (ms_cnt == 16'(POLL_MS)) state_n = START;
      START:     if (ms_cnt == 16'(START_MS)) state_n = RELEASE;
      RELEASE:   if (fall) state_n = RESP_LOW;
                 else if (timeout) begin state_n = IDLE; set_err = 1'b1; end
      RESP_LOW:  if (rise) state_n = RESP_HIGH;
                 else if (timeout) begin state_n = IDLE; set_err = 1'b1; end
      RESP_HIGH: if (fall) state_n = BIT_LOW;
                 else if (timeout) begin state_n = IDLE; set_err = 1'b1; end
      BIT_LOW:   if (rise) state_n = BIT_HIGH;
                 else if (timeout) begin state_n = IDLE; set_err = 1'b1; end
      BIT_HIGH: begin
        if (fall) begin
          shift_en = 1'b1;
          state_n  = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end else if (timeout) begin
          state_n = IDLE;
          set_err = 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (checksum(shift) == shift[7:0]) set_valid = 1'b1;
        else                               set_err   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      presc      <= '0;
      us_cnt     <= '0;
      ms_sub     <= '0;
      ms_cnt     <= '0;
      bit_cnt    <= '0;
      dht_p0     <= 1'b1;
      dht_p1     <= 1'b1;
      dht_p2     <= 1'b1;
      temp_humi  <= '0;
      data_valid <= 1'b0;
      read_err   <= 1'b0;
    end else begin
      // p0/p1 synchronize the line, p2 is the edge-detect delay
      dht_p0 <= dht11;
      dht_p1 <= dht_p0;
      dht_p2 <= dht_p1;
      state  <= state_n;
      presc  <= us_tick ? '0 : presc + 16'd1;
      // A tick coinciding with state entry is counted so pulse widths are phase independent
      if (state_n != state) begin
        us_cnt <= {15'd0, us_tick};
        ms_sub <= '0;
        ms_cnt <= '0;
      end else if (us_tick) begin
        us_cnt <= sat_inc(us_cnt);
        if (ms_sub == 10'd999) begin
          ms_sub <= '0;
          ms_cnt <= sat_inc(ms_cnt);
        end else begin
          ms_sub <= ms_sub + 10'd1;
        end
      end
      if (state == RESP_HIGH) bit_cnt <= '0;
      else if (shift_en)      bit_cnt <= bit_cnt + 6'd1;
      data_valid <= set_valid;
      read_err   <= set_err;
      if (set_valid) temp_humi <= {shift[23:16], shift[39:32]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (shift_en) shift <= {shift[38:0], (us_cnt > 16'(BIT1_US))};
  end

endmodule

// File: tb/tb_dht11_reader.sv
`timescale 1ns/1ps
// Bench for dht11_reader: a behavioural DHT11 on a pulled-up line sends frames,
// a reference model queues expected outcomes and a monitor checks every output pulse.
module tb_dht11_reader;
  localparam int CLK_FREQ   = 2000000;
  localparam int POLL_MS    = 2;
  localparam int START_MS   = 1;
  localparam int BIT1_US    = 40;
  localparam int TIMEOUT_US = 200;

  typedef struct packed {
    logic        is_err;
    logic [15:0] th;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sens_low = 1'b0;
  wire         dht_line;
  logic [15:0] temp_humi;
  logic        data_valid, read_err;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_good = 16'h0000;
  int          hi_us[40];
  longint      t_err, t_fall, t_rise, t_rst;
  bit          start_ok;

  pullup (dht_line);
  assign dht_line = sens_low ? 1'b0 : 1'bz;

  dht11_reader #(
    .CLK_FREQ(CLK_FREQ), .POLL_MS(POLL_MS), .START_MS(START_MS),
    .BIT1_US(BIT1_US), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .dht11(dht_line),
    .temp_humi(temp_humi), .data_valid(data_valid), .read_err(read_err)
  );

  always #250 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: measured %0d ns, expected %0d +/- %0d ns", name, act, exp, tol);
    end
  endtask

  task automatic us(input int n);
    #(n * 1000);
  endtask

  // Reference: decode high times by the threshold rule, then apply the checksum rule.
  task automatic model_push();
    logic [39:0] bits;
    logic [7:0]  b[5];
    int          s;
    exp_t        e;
    for (int i = 0; i < 40; i++) bits[39-i] = (hi_us[i] > BIT1_US);
    for (int k = 0; k < 5; k++) b[k] = bits[39-8*k -: 8];
    s = (int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256;
    if (s == int'(b[4])) begin
      last_good = {b[2], b[0]};
      e.is_err  = 1'b0;
    end else begin
      e.is_err  = 1'b1;
    end
    e.th = last_good;
    sb.push_back(e);
  endtask

  task automatic set_frame(input logic [39:0] bits);
    for (int i = 0; i < 40; i++)
      hi_us[i] = bits[39-i] ? int'($urandom_range(65, 50)) : int'($urandom_range(28, 15));
  endtask

  task automatic random_good_frame();
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    set_frame({b0, b1, b2, b3, 8'(b0 + b1 + b2 + b3)});
  endtask

  task automatic wait_start();
    start_ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (dht_line === 1'b0) begin start_ok = 1'b1; break; end
    end
    t_fall = longint'($time);
    if (start_ok) begin
      start_ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (dht_line === 1'b1) begin start_ok = 1'b1; break; end
      end
      t_rise = longint'($time);
    end
    if (!start_ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_pulse: no complete start pulse seen within budget, line=%b", dht_line);
    end
    #100;
  endtask

  task automatic send_frame(input int abort_at);
    us(20);
    sens_low = 1'b1; us($urandom_range(85, 75));
    sens_low = 1'b0; us($urandom_range(85, 75));
    for (int i = 0; i < 40; i++) begin
      sens_low = 1'b1; us($urandom_range(15, 10));
      sens_low = 1'b0;
      if (i == abort_at) begin
        us(hi_us[i] / 2);
        return;
      end
      us(hi_us[i]);
    end
    model_push();
    sens_low = 1'b1; us(12);
    sens_low = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    check(name, 40'(sb.size()), 40'd0);
  endtask

  initial begin
    logic [15:0] prev_th;
    logic        prev_ev;
    exp_t        e;
    prev_th = 16'h0000;
    prev_ev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_th = temp_humi;
        prev_ev = 1'b0;
      end else begin
        if (data_valid || read_err) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: dv=%b err=%b temp_humi=%h, no event expected",
                     data_valid, read_err, temp_humi);
          end else begin
            e = sb.pop_front();
            if (data_valid === read_err || read_err !== e.is_err || temp_humi !== e.th) begin
              n_bad++;
              $display("FAIL scoreboard: dv=%b err=%b temp_humi=%h, expected err=%b temp_humi=%h",
                       data_valid, read_err, temp_humi, e.is_err, e.th);
            end
          end
          if (read_err) t_err = longint'($time);
          if (prev_ev) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_width: status pulse held 2 cycles, dv=%b err=%b", data_valid, read_err);
          end
        end
        if (!data_valid && temp_humi !== prev_th) begin
          n_cmp++;
          n_bad++;
          $display("FAIL hold: temp_humi %h -> %h without data_valid", prev_th, temp_humi);
        end
        prev_ev = data_valid || read_err;
        prev_th = temp_humi;
      end
    end
  end

  initial begin
    logic [7:0] r0, r1, r2, r3, r4;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_temp_humi", 40'(temp_humi), 40'h0);
    check("rst_data_valid", 40'(data_valid), 40'h0);
    check("rst_read_err", 40'(read_err), 40'h0);
    check("rst_line", 40'(dht_line), 40'h1);
    rst = 1'b0;
    t_rst = longint'($time);

    set_frame({8'h3C, 8'h00, 8'h19, 8'h00, 8'h55});
    wait_start();
    if (start_ok) begin
      check_near("first_start", t_fall - t_rst, 64'd2000000, 64'd5000);
      check_near("start_len", t_rise - t_fall, 64'd1000000, 64'd5000);
      send_frame(-1);
      drain("good_drain");
    end
    check("good_value", 40'(temp_humi), 40'h193C);

    set_frame({8'h3C, 8'h00, 8'h19, 8'h00, 8'h56});
    wait_start();
    if (start_ok) begin
      send_frame(-1);
      drain("badsum_drain");
    end
    check("badsum_hold", 40'(temp_humi), 40'h193C);

    wait_start();
    if (start_ok) begin
      sb.push_back('{is_err: 1'b1, th: last_good});
      drain("nosensor_drain");
      check_near("timeout", t_err - t_rise, 64'(TIMEOUT_US) * 1000, 64'd3000);
      wait_start();
      check_near("retry_start", t_fall - t_err, 64'd2000000, 64'd5000);
    end

    r0 = {4'b0101, 4'($urandom)}; r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    r4 = r0 + r1 + r2 + r3;
    set_frame({r0, r1, r2, r3, r4});
    hi_us[0] = 26; hi_us[1] = 70; hi_us[2] = 40; hi_us[3] = 41;
    if (start_ok) begin
      send_frame(-1);
      drain("threshold_drain");
    end
    check("threshold_bits", 40'(temp_humi[7:4]), 40'b0101);

    set_frame({8'hFF, 8'h01, 8'h10, 8'h05, 8'h15});
    wait_start();
    if (start_ok) begin
      send_frame(-1);
      drain("wrap_drain");
    end
    check("wrap_value", 40'(temp_humi), 40'h10FF);

    random_good_frame();
    wait_start();
    if (start_ok) send_frame(20);
    rst = 1'b1;
    #1;
    check("midrst_temp_humi", 40'(temp_humi), 40'h0);
    check("midrst_data_valid", 40'(data_valid), 40'h0);
    check("midrst_read_err", 40'(read_err), 40'h0);
    check("midrst_line", 40'(dht_line), 40'h1);
    last_good = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t_rst = longint'($time);

    random_good_frame();
    wait_start();
    if (start_ok) begin
      check_near("post_rst_start", t_fall - t_rst, 64'd2000000, 64'd5000);
      send_frame(-1);
      drain("clean_drain");
    end
    check("clean_value", 40'(temp_humi), 40'(last_good));

    repeat (20) @(negedge clk);
    check("queue_empty", 40'(sb.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
